multicycle_main_fsm: RTL
========================

Name: multicycle_main_fsm

Overview:
- Main control FSM for the multi-cycle RV32I core; successor to the single-cycle opcode decoder.
- Sequences the shared datapath: one memory port, one ALU, IR, PC, ALUOut and data registers.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Stalls on a memory-ready handshake.
- Branch compare outcome (branch_cond) is computed outside this block, from ALU flags and funct3.

Parameters:
- STATE_W, 4, state register width; must hold 14 states.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode field from IR
- mem_ready  in  1  memory access completes this cycle
- branch_cond  in  1  branch-taken condition from ALU/branch logic
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  data memory write strobe
- ir_write  out  1  IR/oldPC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  result select: 00=ALUOut, 01=Data, 10=ALU result
- alu_src_a  out  2  ALU A select: 00=PC, 01=oldPC, 10=rs1, 11=zero
- alu_src_b  out  2  ALU B select: 00=rs2, 01=imm, 10=const 4
- alu_op  out  2  to ALU decoder: 00=add, 01=branch compare, 10=funct-decoded
- imm_src  out  3  immediate format
- illegal  out  1  illegal opcode flag (feature-dependent)
- state_o  out  STATE_W  current state, debug

Behaviour:
- Opcodes:
  - R 0110011, I 0010011, LOAD 0000011, S 0100011, B 1100011
  - JAL 1101111, JALR 1100111, LUI 0110111
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JALR_ADR, JUMP, LUI_EX, TRAP.
- State register: async reset to FETCH. Outputs are Moore (decoded from state) except the mem_ready-gated strobes and pc_write. Any output not listed for a state is 0.
- FETCH:
  - adr_src=0, a=00, b=10, op=00, result_src=10.
  - ir_write=pc_update=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: a=01, b=01, op=00 (branch/jump target into ALUOut). Next state by op:
  - R -> EXECR
  - I -> EXECI
  - LOAD/S -> MEMADR
  - B -> BRANCH
  - JAL -> JUMP
  - JALR -> JALR_ADR
  - LUI -> LUI_EX
  - other opcodes -> see Optional Feature.
- MEMADR: a=10, b=01, op=00. LOAD -> MEMREAD; S -> MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds until mem_ready; then MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 (held until the access completes). Leaves to FETCH in the cycle mem_ready=1.
- EXECR: a=10, b=00, op=10 -> ALUWB.
- EXECI: a=10, b=01, op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: a=10, b=00, op=01, result_src=00, branch=1 -> FETCH.
- JALR_ADR: a=10, b=01, op=00 (target into ALUOut) -> JUMP.
- JUMP: a=01, b=10, op=00, result_src=00, pc_update=1 (PC<=target, ALU computes oldPC+4) -> ALUWB.
- LUI_EX: a=11, b=01, op=00 -> ALUWB.
- pc_write = pc_update | (branch & branch_cond). branch_cond is ignored outside BRANCH.
- imm_src is combinational from op, valid in every state:
  - I/LOAD/JALR 000, S 001, B 010, LUI 011, JAL 100
  - other opcodes 000
- While rst_n=0: all outputs 0 except alu_src_b=10, result_src=10 (FETCH values). pc_write, ir_write, mem_write, reg_write are forced 0.
- Reset mid-instruction aborts it. The first FETCH happens on the first clk edge after deassertion.
- Each instruction performs exactly one reg_write pulse at most and one mem_write access at most.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP.
  - TRAP asserts illegal=1 and holds all strobes at 0.
  - The FSM stays in TRAP until rst_n is asserted.
- Undefined: an unknown opcode goes from DECODE to FETCH (executes as a NOP). illegal is tied 0 and TRAP is unreachable.

Test Plan:
- Reset: rst_n=0 mid-MEMWRITE -> mem_write drops immediately, state_o=FETCH. After release with mem_ready=1: ir_write=1 on the first cycle, state DECODE on the next.
- R-type: op=0110011, mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB (4 cycles). alu_op=10 in EXECR. reg_write=1 only in ALUWB.
- Load with stall: op=0000011, mem_ready held 0 for 3 cycles in MEMREAD -> MEMREAD lasts 4 cycles. reg_write with result_src=01 occurs once. Total 8 cycles.
- Branch: op=1100011 with branch_cond=1, then branch_cond=0 -> pc_write=1, resp. 0, in the BRANCH cycle. imm_src=010 and reg_write=0 throughout.
- JALR: op=1100111 -> FETCH, DECODE, JALR_ADR, JUMP, ALUWB. pc_write=1 in JUMP; reg_write=1 in ALUWB. imm_src=000.
- Illegal: op=1111111 -> with ILLEGAL_TRAP_EN, TRAP entered with illegal=1 and held for 20 cycles until reset. Without the macro, returns to FETCH after DECODE with no strobes.

Source files
------------

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multi-cycle main FSM (master) and the shared datapath (slave).
interface multicycle_main_fsm_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic               mem_ready;
  logic               branch_cond;
  logic               pc_write;
  logic               adr_src;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [2:0]         imm_src;
  logic               illegal;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, mem_ready, branch_cond,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal, state_o
  );

  modport slave (
    output op, mem_ready, branch_cond,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal, state_o
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP with illegal=1; otherwise they run as a NOP.
module multicycle_main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_main_fsm_if.master bus
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JALR_ADR, JUMP, LUI_EX, TRAP
  } state_e;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_upd;
    logic       fetch;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic [2:0] imm_d;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
`endif

  // Moore decode; registered against the next state so outputs come straight from flops.
  function automatic ctrl_t moore(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.alu_src_b = 2'b10; c.result_src = 2'b10; c.fetch = 1'b1; end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      ALUWB:    c.reg_write = 1'b1;
      BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      JALR_ADR: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      JUMP:     begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_upd = 1'b1; end
      LUI_EX:   begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          OP_R:          state_d = EXECR;
          OP_I:          state_d = EXECI;
          OP_LOAD, OP_S: state_d = MEMADR;
          OP_B:          state_d = BRANCH;
          OP_JAL:        state_d = JUMP;
          OP_JALR:       state_d = JALR_ADR;
          OP_LUI:        state_d = LUI_EX;
`ifdef ILLEGAL_TRAP_EN
          default:       state_d = TRAP;
`else
          default:       state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = bus.mem_ready ? FETCH : MEMWRITE;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JALR_ADR: state_d = JUMP;
      JUMP:     state_d = ALUWB;
      LUI_EX:   state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ctrl_q    <= moore(FETCH);
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= moore(state_d);
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= (state_d == TRAP);
`endif
    end
  end

  always_comb begin
    imm_d = 3'b000;
    case (bus.op)
      OP_S:    imm_d = 3'b001;
      OP_B:    imm_d = 3'b010;
      OP_LUI:  imm_d = 3'b011;
      OP_JAL:  imm_d = 3'b100;
      default: imm_d = 3'b000;
    endcase
  end

  // The reset register values already equal FETCH; rst_n only masks the combinational strobes.
  assign bus.ir_write   = rst_n & ctrl_q.fetch & bus.mem_ready;
  assign bus.pc_write   = rst_n & ((ctrl_q.fetch & bus.mem_ready) | ctrl_q.pc_upd |
                                   (ctrl_q.branch & bus.branch_cond));
  assign bus.imm_src    = rst_n ? imm_d : 3'b000;
  assign bus.adr_src    = ctrl_q.adr_src;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.result_src = ctrl_q.result_src;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.state_o    = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal    = illegal_q;
`else
  assign bus.illegal    = 1'b0;
`endif

endmodule
